// File: rtl/host_write_scheduler_pkg.sv
// ============================================================================
// Module : gfx_host_pkg
// Brief  : Shared types and constants for the host write scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gfx_host_pkg;

    localparam int REG_SEL_BIT = 15;
    localparam int GFX_ADDR_W  = 13;
    localparam int GFX_DATA_W  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic                  sel;
        logic [GFX_ADDR_W-1:0] addr;
        logic [GFX_DATA_W-1:0] data;
    } wr_entry_t;

    function automatic wr_entry_t pack_request(
        input logic                  sel,
        input logic [GFX_ADDR_W-1:0] addr,
        input logic [GFX_DATA_W-1:0] data
    );
        wr_entry_t e;
        e.sel  = sel;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/host_write_scheduler_if.sv
// ============================================================================
// Module : host_write_scheduler_if
// Brief  : Adapter-side request bus and graphics-core write port bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface host_write_scheduler_if #(
    parameter int DEPTH = 8
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic [15:0]        in_addr;
    logic [15:0]        in_data;
    logic               in_ready;
    logic               gfx_vram_cs;
    logic               gfx_reg_cs;
    logic [12:0]        gfx_addr;
    logic [15:0]        gfx_data;
    logic               gfx_done;
    logic               gfx_write_avail;
    logic [LEVEL_W-1:0] fifo_level;
    logic               overflow;
    logic               timeout_err;
    logic               clear_errors;

    modport slave (
        input  in_valid, in_addr, in_data, gfx_done, gfx_write_avail, clear_errors,
        output in_ready, gfx_vram_cs, gfx_reg_cs, gfx_addr, gfx_data,
               fifo_level, overflow, timeout_err
    );

    modport master (
        output in_valid, in_addr, in_data, gfx_done, gfx_write_avail, clear_errors,
        input  in_ready, gfx_vram_cs, gfx_reg_cs, gfx_addr, gfx_data,
               fifo_level, overflow, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/host_write_scheduler_fifo.sv
// ============================================================================
// Module : host_write_fifo
// Brief  : Single-clock FIFO of pending host writes; head is read combinationally.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module host_write_fifo
    import gfx_host_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     push_i,
    input  wire logic                     pop_i,
    input  wire wr_entry_t                data_i,
    output wr_entry_t                     data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);

    wr_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (level_q == C_DEPTH);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/host_write_scheduler.sv
// ============================================================================
// Module : host_write_scheduler
// Brief  : Queues host writes and issues them one at a time to the gfx core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module host_write_scheduler
    import gfx_host_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic              clk,
    input  wire logic              reset,
    host_write_scheduler_if.slave  bus
);

    localparam int LEVEL_W = $clog2(DEPTH) + 1;
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    wr_state_e         state_q;
    logic              vram_cs_q;
    logic              reg_cs_q;
    logic [12:0]       addr_q;
    logic [15:0]       data_q;
    logic [15:0]       cnt_q;
    logic              overflow_q;
    logic              overflow_d;
    logic              timeout_q;
    logic              timeout_d;

    wr_entry_t         w_req;
    wr_entry_t         w_head;
    logic              w_full;
    logic              w_empty;
    logic [LEVEL_W-1:0] w_level;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_done_hit;
    logic              w_timeout_hit;

    assign w_req = pack_request(bus.in_addr[REG_SEL_BIT], bus.in_addr[13:1], bus.in_data);

    assign w_pop  = (state_q == IDLE) && !w_empty && bus.gfx_write_avail;
    assign w_push = bus.in_valid && (!w_full || w_pop);
    assign w_drop = bus.in_valid && !w_push;

    // Done on the final counted cycle completes the write rather than aborting it.
    assign w_done_hit    = (state_q == ACTIVE) && bus.gfx_done;
    assign w_timeout_hit = (state_q == ACTIVE) && !bus.gfx_done && (cnt_q == C_TIMEOUT_LAST);

    host_write_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (w_req),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            vram_cs_q <= 1'b0;
            reg_cs_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_pop) begin
                        addr_q    <= w_head.addr;
                        data_q    <= w_head.data;
                        vram_cs_q <= !w_head.sel;
                        reg_cs_q  <= w_head.sel;
                        cnt_q     <= '0;
                        state_q   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_done_hit || w_timeout_hit) begin
                        vram_cs_q <= 1'b0;
                        reg_cs_q  <= 1'b0;
                        state_q   <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                end
                default: begin
                    vram_cs_q <= 1'b0;
                    reg_cs_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // A new error event in the clearing cycle keeps its flag set.
    always_comb begin
        overflow_d = w_drop        || (overflow_q && !bus.clear_errors);
        timeout_d  = w_timeout_hit || (timeout_q  && !bus.clear_errors);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.in_ready    = !w_full;
    assign bus.gfx_vram_cs = vram_cs_q;
    assign bus.gfx_reg_cs  = reg_cs_q;
    assign bus.gfx_addr    = addr_q;
    assign bus.gfx_data    = data_q;
    assign bus.fifo_level  = w_level;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_host_write_scheduler.sv
// ============================================================================
// Module : tb_host_write_scheduler
// Brief  : Directed self-checking bench for host_write_scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_host_write_scheduler;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 4;
    localparam int NEVER   = 1000;

    typedef struct packed {
        logic        sel;
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    wr_t  log_q[$];
    int   dur_q[$];
    int   gap_q[$];
    int   hi_cnt   = 0;
    int   lo_cnt   = 100;
    int   done_lat = 0;
    bit   both_hi  = 1'b0;
    logic cs_any;

    always #5 clk = ~clk;

    host_write_scheduler_if #(.DEPTH(DEPTH)) bus ();

    host_write_scheduler #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign cs_any       = bus.gfx_vram_cs || bus.gfx_reg_cs;
    assign bus.gfx_done = cs_any && (hi_cnt == done_lat);

    // Graphics-core model: logs each write at cs rise, its cs-high length and preceding gap.
    always @(posedge clk) begin
        if (cs_any) begin
            if (hi_cnt == 0) begin
                log_q.push_back({bus.gfx_reg_cs, bus.gfx_addr, bus.gfx_data});
                gap_q.push_back(lo_cnt);
            end
            hi_cnt <= hi_cnt + 1;
            lo_cnt <= 0;
        end else begin
            if (hi_cnt != 0) dur_q.push_back(hi_cnt);
            hi_cnt <= 0;
            lo_cnt <= lo_cnt + 1;
        end
        if (bus.gfx_vram_cs && bus.gfx_reg_cs) both_hi <= 1'b1;
    end

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    task automatic rel();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (dur_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_logs();
        log_q.delete();
        dur_q.delete();
        gap_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.gfx_vram_cs !== 1'b0) begin failures++; $display("FAIL reset_vram_cs got=%b exp=0", bus.gfx_vram_cs); end
        checks++; if (bus.gfx_reg_cs !== 1'b0) begin failures++; $display("FAIL reset_reg_cs got=%b exp=0", bus.gfx_reg_cs); end
        checks++; if (bus.gfx_addr !== 13'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.gfx_addr); end
        checks++; if (bus.gfx_data !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.gfx_data); end
        checks++; if (bus.fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if ({bus.overflow, bus.timeout_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {bus.overflow, bus.timeout_err}); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        done_lat = 0;
        bus.gfx_write_avail = 1'b1;
        push(16'h0012, 16'hBEEF);
        rel();
        wait_writes(1, 20, ok);
        repeat (4) @(negedge clk);
        checks++; if (!ok || log_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", log_q.size()); end
        else begin
            checks++; if (log_q[0] !== wr_t'({1'b0, 13'h009, 16'hBEEF})) begin failures++; $display("FAIL single_entry got=%h exp=%h", log_q[0], wr_t'({1'b0, 13'h009, 16'hBEEF})); end
            checks++; if (dur_q[0] != 1) begin failures++; $display("FAIL single_cs_len got=%0d exp=1", dur_q[0]); end
        end
    endtask

    task automatic test_order();
        bit ok;
        clear_logs();
        done_lat = 2;
        push(16'h8004, 16'h1111);
        push(16'h0006, 16'h2222);
        rel();
        wait_writes(2, 40, ok);
        checks++; if (!ok || log_q.size() != 2) begin failures++; $display("FAIL order_count got=%0d exp=2", log_q.size()); end
        else begin
            checks++; if (log_q[0] !== wr_t'({1'b1, 13'h002, 16'h1111})) begin failures++; $display("FAIL order_first got=%h exp=%h", log_q[0], wr_t'({1'b1, 13'h002, 16'h1111})); end
            checks++; if (dur_q[0] != 3) begin failures++; $display("FAIL order_first_len got=%0d exp=3", dur_q[0]); end
            checks++; if (log_q[1] !== wr_t'({1'b0, 13'h003, 16'h2222})) begin failures++; $display("FAIL order_second got=%h exp=%h", log_q[1], wr_t'({1'b0, 13'h003, 16'h2222})); end
            checks++; if (dur_q[1] != 3) begin failures++; $display("FAIL order_second_len got=%0d exp=3", dur_q[1]); end
            checks++; if (gap_q[1] < 1) begin failures++; $display("FAIL order_gap got=%0d exp>=1", gap_q[1]); end
        end
        checks++; if (both_hi !== 1'b0) begin failures++; $display("FAIL order_both_cs got=%b exp=0", both_hi); end
    endtask

    task automatic test_back_pressure();
        bit ok;
        clear_logs();
        done_lat = 0;
        bus.gfx_write_avail = 1'b0;
        for (int i = 0; i < 9; i++) push(16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
        rel();
        checks++; if (bus.fifo_level !== 4'd8) begin failures++; $display("FAIL bp_level got=%0d exp=8", bus.fifo_level); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow got=%b exp=1", bus.overflow); end
        bus.gfx_write_avail = 1'b1;
        wait_writes(8, 80, ok);
        repeat (10) @(negedge clk);
        checks++; if (!ok || log_q.size() != 8) begin failures++; $display("FAIL bp_drain_count got=%0d exp=8", log_q.size()); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_q[i] !== wr_t'({1'b0, 13'(13'h080 + i), 16'(16'hA000 + i)})) begin
                    failures++;
                    $display("FAIL bp_entry%0d got=%h exp=%h", i, log_q[i], wr_t'({1'b0, 13'(13'h080 + i), 16'(16'hA000 + i)}));
                end
            end
        end
        @(negedge clk) bus.clear_errors = 1'b1;
        @(negedge clk) bus.clear_errors = 1'b0;
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL bp_clear got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        done_lat = NEVER;
        bus.gfx_write_avail = 1'b1;
        push(16'h0020, 16'h5555);
        push(16'h8022, 16'h6666);
        rel();
        wait_writes(2, 40, ok);
        checks++; if (!ok || log_q.size() != 2) begin failures++; $display("FAIL to_count got=%0d exp=2", log_q.size()); end
        else begin
            checks++; if (log_q[0] !== wr_t'({1'b0, 13'h010, 16'h5555})) begin failures++; $display("FAIL to_first got=%h exp=%h", log_q[0], wr_t'({1'b0, 13'h010, 16'h5555})); end
            checks++; if (dur_q[0] != TIMEOUT) begin failures++; $display("FAIL to_first_len got=%0d exp=%0d", dur_q[0], TIMEOUT); end
            checks++; if (log_q[1] !== wr_t'({1'b1, 13'h011, 16'h6666})) begin failures++; $display("FAIL to_next got=%h exp=%h", log_q[1], wr_t'({1'b1, 13'h011, 16'h6666})); end
            checks++; if (dur_q[1] != TIMEOUT) begin failures++; $display("FAIL to_next_len got=%0d exp=%0d", dur_q[1], TIMEOUT); end
        end
        checks++; if (bus.timeout_err !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", bus.timeout_err); end
        @(negedge clk) bus.clear_errors = 1'b1;
        @(negedge clk) bus.clear_errors = 1'b0;
        checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear got=%b exp=0", bus.timeout_err); end
        done_lat = 0;
    endtask

    task automatic test_full_pop();
        bit ok;
        clear_logs();
        done_lat = 0;
        bus.gfx_write_avail = 1'b0;
        for (int i = 0; i < 8; i++) push(16'(16'h0040 + 2 * i), 16'(16'hC000 + i));
        rel();
        checks++; if (bus.fifo_level !== 4'd8) begin failures++; $display("FAIL fp_level_full got=%0d exp=8", bus.fifo_level); end
        // Push lands in the same cycle the idle FSM pops the head.
        @(negedge clk);
        bus.gfx_write_avail = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_addr  = 16'h8100;
        bus.in_data  = 16'hD00D;
        rel();
        checks++; if (bus.fifo_level !== 4'd8) begin failures++; $display("FAIL fp_level_hold got=%0d exp=8", bus.fifo_level); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL fp_overflow got=%b exp=0", bus.overflow); end
        wait_writes(9, 80, ok);
        checks++; if (!ok || log_q.size() != 9) begin failures++; $display("FAIL fp_count got=%0d exp=9", log_q.size()); end
        else begin
            checks++; if (log_q[0] !== wr_t'({1'b0, 13'h020, 16'hC000})) begin failures++; $display("FAIL fp_head got=%h exp=%h", log_q[0], wr_t'({1'b0, 13'h020, 16'hC000})); end
            checks++; if (log_q[8] !== wr_t'({1'b1, 13'h080, 16'hD00D})) begin failures++; $display("FAIL fp_tail got=%h exp=%h", log_q[8], wr_t'({1'b1, 13'h080, 16'hD00D})); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n0;
        clear_logs();
        done_lat = NEVER;
        bus.gfx_write_avail = 1'b1;
        push(16'h0002, 16'h7777);
        push(16'h0004, 16'h8888);
        rel();
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cs_any) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin failures++; $display("FAIL rm_cs_rise got=0 exp=1"); end
        #2 reset = 1'b1;
        #1;
        checks++; if (cs_any !== 1'b0) begin failures++; $display("FAIL rm_cs_async got=%b exp=0", cs_any); end
        checks++; if (bus.fifo_level !== 4'd0) begin failures++; $display("FAIL rm_level got=%0d exp=0", bus.fifo_level); end
        @(negedge clk) reset = 1'b0;
        done_lat = 0;
        n0 = log_q.size();
        repeat (20) @(negedge clk);
        checks++; if (log_q.size() != n0) begin failures++; $display("FAIL rm_no_issue got=%0d exp=%0d", log_q.size(), n0); end
        push(16'h0008, 16'h9999);
        rel();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (log_q.size() > n0) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL rm_new_write got=none exp=write"); end
        else begin
            checks++; if (log_q[n0] !== wr_t'({1'b0, 13'h004, 16'h9999})) begin failures++; $display("FAIL rm_new_entry got=%h exp=%h", log_q[n0], wr_t'({1'b0, 13'h004, 16'h9999})); end
        end
    endtask

    initial begin
        bus.in_valid        = 1'b0;
        bus.in_addr         = 16'h0;
        bus.in_data         = 16'h0;
        bus.gfx_write_avail = 1'b0;
        bus.clear_errors    = 1'b0;
        test_reset();
        test_single();
        test_order();
        test_back_pressure();
        test_timeout();
        test_full_pop();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
